// File: rtl/vx_vector_pkg.sv
// Shared vector-unit definitions: beat count, index widths and lane/vector types.
// Used by both the unroll and repack stages so the beat ordering and
// per-beat lane placement are derived from one place.
package vx_vector_pkg;

    localparam int VX_VLEN        = 256;
    localparam int VX_NUM_THREADS = 4;
    localparam int VX_XLEN        = 32;

    // Number of beats needed to carry one VLEN-wide vector NUM_THREADS*XLEN
    // bits at a time. Returns 0 for any configuration that does not divide
    // evenly, which the users turn into an elaboration error.
    function automatic int vec_beats(input int vlen, input int nt, input int xlen);
        if (nt * xlen <= 0) begin
            return 0;
        end
        if ((vlen % (nt * xlen)) != 0) begin
            return 0;
        end
        return vlen / (nt * xlen);
    endfunction

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VX_BEATS  = vec_beats(VX_VLEN, VX_NUM_THREADS, VX_XLEN);
    localparam int VX_BEAT_W = log2up(VX_BEATS);
    localparam int VX_THR_W  = log2up(VX_NUM_THREADS);

    typedef logic [VX_XLEN-1:0] lane_t;
    typedef logic [VX_VLEN-1:0] vreg_t;

endpackage

// File: rtl/vx_vector_repack.sv
// Purpose: rebuilds VLEN-wide per-thread vectors from XLEN-lane result beats
//          arriving thread-major, beat-minor, and presents them for writeback.
// Latency: final beat of a thread accepted in cycle N -> valid_out in N+1.
// Backpressure: only the final beat stalls on a full, non-draining output
//          register; non-final beats keep accumulating. ready_in is
//          combinational from ready_out, so drain and load can share a cycle.
//
// Ports: clk/reset (sync, active-high); valid_in/ready_in/data_in/tag_in
//        input beat handshake; valid_out/ready_out/data_out/thread_out/
//        tag_out/eop_out packed vector handshake; busy = work in flight.
module vx_vector_repack
    import vx_vector_pkg::*;
#(
    parameter int VLEN        = VX_VLEN,
    parameter int NUM_THREADS = VX_NUM_THREADS,
    parameter int XLEN        = VX_XLEN,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 valid_in,
    output logic                                 ready_in,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]     data_in,
    input  logic [TAG_WIDTH-1:0]                 tag_in,
    output logic                                 valid_out,
    input  logic                                 ready_out,
    output logic [VLEN-1:0]                      data_out,
    output logic [log2up(NUM_THREADS)-1:0]       thread_out,
    output logic [TAG_WIDTH-1:0]                 tag_out,
    output logic                                 eop_out,
    output logic                                 busy
);

    localparam int BEATS   = vec_beats(VLEN, NUM_THREADS, XLEN);
    localparam int BEAT_W  = log2up(BEATS);
    localparam int THR_W   = log2up(NUM_THREADS);
    localparam int SLICE_W = NUM_THREADS * XLEN;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [THR_W-1:0]  LAST_THR  = THR_W'(NUM_THREADS - 1);

    generate
        if (BEATS < 1) begin : g_bad_cfg
            $error("vx_vector_repack: VLEN must be a positive multiple of NUM_THREADS*XLEN");
        end
    endgenerate

    logic [BEAT_W-1:0]    r_beat_cntr;
    logic [THR_W-1:0]     r_thread_cntr;
    logic [VLEN-1:0]      r_accum;
    logic [TAG_WIDTH-1:0] r_tag;

    logic                 r_valid_out;
    logic [VLEN-1:0]      r_data_out;
    logic [THR_W-1:0]     r_thread_out;
    logic [TAG_WIDTH-1:0] r_tag_out;
    logic                 r_eop_out;

    logic                 w_final;
    logic                 w_first;
    logic                 w_accept;
    logic [VLEN-1:0]      w_merged;
    logic [THR_W-1:0]     w_thread_nxt;

    assign w_final  = (r_beat_cntr == LAST_BEAT);
    assign w_first  = (r_beat_cntr == '0) && (r_thread_cntr == '0);

    // Only the final beat needs the output register; earlier beats land in
    // the accumulator and never wait on writeback.
    assign ready_in = !w_final || !r_valid_out || ready_out;
    assign w_accept = valid_in && ready_in;

    assign w_thread_nxt = (r_thread_cntr == LAST_THR) ? '0 : r_thread_cntr + THR_W'(1);

    // Accumulator with the current beat's lanes dropped into their slice.
    // On the final beat this is the complete vector.
    always_comb begin
        w_merged = r_accum;
        w_merged[r_beat_cntr * SLICE_W +: SLICE_W] = data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cntr   <= '0;
            r_thread_cntr <= '0;
            r_accum       <= '0;
            r_tag         <= '0;
            r_valid_out   <= 1'b0;
            r_data_out    <= '0;
            r_thread_out  <= '0;
            r_tag_out     <= '0;
            r_eop_out     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_tag <= tag_in;
                end
                if (w_final) begin
                    r_beat_cntr   <= '0;
                    r_thread_cntr <= w_thread_nxt;
                    r_data_out    <= w_merged;
                    r_thread_out  <= r_thread_cntr;
                    r_eop_out     <= (r_thread_cntr == LAST_THR);
                    // With one beat per thread the tag register has not been
                    // written yet on the first beat, so forward tag_in.
                    r_tag_out     <= w_first ? tag_in : r_tag;
                end else begin
                    r_accum     <= w_merged;
                    r_beat_cntr <= r_beat_cntr + BEAT_W'(1);
                end
            end

            // A load in the same cycle as a drain wins, giving zero bubble.
            if (w_accept && w_final) begin
                r_valid_out <= 1'b1;
            end else if (ready_out) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign valid_out  = r_valid_out;
    assign data_out   = r_data_out;
    assign thread_out = r_thread_out;
    assign tag_out    = r_tag_out;
    assign eop_out    = r_eop_out;
    assign busy       = r_valid_out || (r_beat_cntr != '0) || (r_thread_cntr != '0);

endmodule

// File: tb/tb_vx_vector_repack.sv
module tb_vx_vector_repack;
    import vx_vector_pkg::*;

    localparam int NT    = 4;
    localparam int XL    = 32;
    localparam int VL    = 256;
    localparam int VLB   = 128;
    localparam int BEATS = 2;
    localparam int SW    = NT * XL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: VLEN=256 (two beats per thread)
    logic                  reset;
    logic                  valid_in, ready_in, ready_out, valid_out, eop_out, busy;
    logic [NT-1:0][XL-1:0] data_in;
    logic [7:0]            tag_in, tag_out;
    logic [VL-1:0]         data_out;
    logic [1:0]            thread_out;

    // DUT B: VLEN=128 (one beat per thread)
    logic                  b_valid_in, b_ready_in, b_ready_out, b_valid_out, b_eop_out, b_busy;
    logic [NT-1:0][XL-1:0] b_data_in;
    logic [7:0]            b_tag_in, b_tag_out;
    logic [VLB-1:0]        b_data_out;
    logic [1:0]            b_thread_out;

    vx_vector_repack #(.VLEN(VL), .NUM_THREADS(NT), .XLEN(XL), .TAG_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .thread_out(thread_out), .tag_out(tag_out), .eop_out(eop_out), .busy(busy)
    );

    vx_vector_repack #(.VLEN(VLB), .NUM_THREADS(NT), .XLEN(XL), .TAG_WIDTH(8)) u_dut_b (
        .clk(clk), .reset(reset),
        .valid_in(b_valid_in), .ready_in(b_ready_in), .data_in(b_data_in), .tag_in(b_tag_in),
        .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out),
        .thread_out(b_thread_out), .tag_out(b_tag_out), .eop_out(b_eop_out), .busy(b_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] lanes(input int base);
        logic [SW-1:0] r;
        for (int i = 0; i < NT; i++) r[i*XL +: XL] = XL'(base + i);
        return r;
    endfunction

    function automatic logic [VL-1:0] place(input logic [VL-1:0] acc, input int b, input logic [SW-1:0] d);
        acc[b*SW +: SW] = d;
        return acc;
    endfunction

    // Reference model: a running count of accepted beats since reset; beat
    // and thread positions follow from plain division, the vector from
    // slotting each beat into its place.
    int             m_k;
    int             m_b, m_t;
    logic           m_first, m_ready, m_busy;
    logic [VL-1:0]  m_acc;
    logic [7:0]     m_tag;
    logic           e_vld, e_eop;
    logic [VL-1:0]  e_dat;
    logic [1:0]     e_thr;
    logic [7:0]     e_tag;

    assign m_b     = m_k % BEATS;
    assign m_t     = (m_k / BEATS) % NT;
    assign m_first = (m_k % (BEATS * NT)) == 0;
    assign m_ready = (m_b != BEATS - 1) || !e_vld || ready_out;
    assign m_busy  = e_vld || ((m_k % (BEATS * NT)) != 0);

    always @(posedge clk) begin
        if (reset) begin
            m_k <= 0; m_acc <= '0; m_tag <= '0;
            e_vld <= 1'b0; e_dat <= '0; e_thr <= '0; e_tag <= '0; e_eop <= 1'b0;
        end else if (valid_in && m_ready) begin
            m_k   <= m_k + 1;
            m_acc <= place(m_acc, m_b, data_in);
            if (m_first) m_tag <= tag_in;
            if (m_b == BEATS - 1) begin
                e_vld <= 1'b1;
                e_dat <= place(m_acc, m_b, data_in);
                e_thr <= m_t[1:0];
                e_tag <= m_first ? tag_in : m_tag;
                e_eop <= (m_t == NT - 1);
            end else if (ready_out) begin
                e_vld <= 1'b0;
            end
        end else if (ready_out) begin
            e_vld <= 1'b0;
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("m_ready_in", {255'd0, ready_in}, {255'd0, m_ready});
            chk("m_valid_out", {255'd0, valid_out}, {255'd0, e_vld});
            chk("m_data_out", data_out, e_dat);
            chk("m_thread_out", {254'd0, thread_out}, {254'd0, e_thr});
            chk("m_tag_out", {248'd0, tag_out}, {248'd0, e_tag});
            chk("m_eop_out", {255'd0, eop_out}, {255'd0, e_eop});
            chk("m_busy", {255'd0, busy}, {255'd0, m_busy});
        end
    end

    // Random writeback backpressure
    logic rnd_rdy = 1'b0;
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    // Capture of completed handshakes (ready_out only changes after posedge)
    logic          cap_en = 1'b0;
    logic [VL-1:0] cap_q[$];
    always @(negedge clk) begin
        if (cap_en && valid_out && ready_out) cap_q.push_back(data_out);
    end

    // Presents one beat and holds it until accepted; called at posedge+1.
    task automatic send(input logic [SW-1:0] d, input logic [7:0] tg);
        logic r;
        bit   ok;
        ok = 1'b0;
        valid_in = 1'b1; data_in = d; tag_in = tg;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); r = ready_in;
            @(posedge clk); #1;
            if (r) begin ok = 1'b1; break; end
        end
        valid_in = 1'b0;
        if (!ok) chk("send_timeout", 256'd0, 256'd1);
    endtask

    typedef struct {
        logic        vld;
        int          base;
        logic [7:0]  tag;
        logic        rdy;
        logic        rdy_in_exp;
        logic        vld_exp;
        logic [1:0]  thr_exp;
        logic        eop_exp;
        logic [7:0]  tag_exp;
        logic [31:0] w0_exp;
        logic [31:0] w7_exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int c, h;
        // Scenario 1 table: 8 back-to-back beats, then one idle cycle.
        for (int r = 0; r < 9; r++) begin
            tbl[r].vld        = (r < 8);
            tbl[r].base       = (r / 2) * 32 + (r % 2) * 16;
            tbl[r].tag        = (r == 0) ? 8'h5A : 8'hA5;
            tbl[r].rdy        = 1'b1;
            tbl[r].rdy_in_exp = 1'b1;
            tbl[r].vld_exp    = (r < 8) && (r % 2 == 1);
            c = (r + 1) / 2;
            if (c > 4) c = 4;
            h = c - 1;
            tbl[r].thr_exp = (c == 0) ? 2'd0 : 2'(h);
            tbl[r].eop_exp = (c != 0) && (h == 3);
            tbl[r].tag_exp = (c == 0) ? 8'h00 : 8'h5A;
            tbl[r].w0_exp  = (c == 0) ? 32'h0 : 32'(h * 32);
            tbl[r].w7_exp  = (c == 0) ? 32'h0 : 32'(h * 32 + 8'h13);
        end

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0; data_in = '0; tag_in = '0;
        b_valid_in = 1'b0; b_ready_out = 1'b0; b_data_in = '0; b_tag_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ready_in", {255'd0, ready_in}, 256'd1);
        chk("rst_valid_out", {255'd0, valid_out}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_data_out", data_out, 256'd0);
        @(posedge clk); #1;

        // Scenario 1
        for (int r = 0; r < 9; r++) begin
            valid_in = tbl[r].vld; data_in = lanes(tbl[r].base);
            tag_in = tbl[r].tag; ready_out = tbl[r].rdy;
            @(negedge clk);
            chk("s1_ready_in", {255'd0, ready_in}, {255'd0, tbl[r].rdy_in_exp});
            @(posedge clk); #1;
            chk("s1_valid_out", {255'd0, valid_out}, {255'd0, tbl[r].vld_exp});
            chk("s1_thread_out", {254'd0, thread_out}, {254'd0, tbl[r].thr_exp});
            chk("s1_eop_out", {255'd0, eop_out}, {255'd0, tbl[r].eop_exp});
            chk("s1_tag_out", {248'd0, tag_out}, {248'd0, tbl[r].tag_exp});
            chk("s1_word0", {224'd0, data_out[31:0]}, {224'd0, tbl[r].w0_exp});
            chk("s1_word7", {224'd0, data_out[255:224]}, {224'd0, tbl[r].w7_exp});
        end
        valid_in = 1'b0;

        // Scenario 2: output stall with non-final beat still accepted
        ready_out = 1'b1;
        send(lanes(32'h100), 8'h77);
        send(lanes(32'h110), 8'h00);
        ready_out = 1'b0;
        send(lanes(32'h120), 8'h00);
        valid_in = 1'b1; data_in = lanes(32'h130);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s2_ready_in_stall", {255'd0, ready_in}, 256'd0);
            chk("s2_held_valid", {255'd0, valid_out}, 256'd1);
            chk("s2_held_data", data_out, {lanes(32'h110), lanes(32'h100)});
            chk("s2_held_thread", {254'd0, thread_out}, 256'd0);
            @(posedge clk); #1;
        end
        ready_out = 1'b1;
        @(negedge clk);
        chk("s2_ready_in_release", {255'd0, ready_in}, 256'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("s2_valid_after", {255'd0, valid_out}, 256'd1);
        chk("s2_thread_after", {254'd0, thread_out}, 256'd1);
        chk("s2_data_after", data_out, {lanes(32'h130), lanes(32'h120)});
        chk("s2_tag_after", {248'd0, tag_out}, 256'h77);

        // Scenario 3: final beat meets a full, draining output register
        ready_out = 1'b0;
        send(lanes(32'h140), 8'h00);
        ready_out = 1'b1;
        valid_in = 1'b1; data_in = lanes(32'h150);
        @(negedge clk);
        chk("s3_valid_before", {255'd0, valid_out}, 256'd1);
        chk("s3_ready_in", {255'd0, ready_in}, 256'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("s3_valid_next", {255'd0, valid_out}, 256'd1);
        chk("s3_thread_next", {254'd0, thread_out}, 256'd2);
        chk("s3_data_next", data_out, {lanes(32'h150), lanes(32'h140)});
        send(lanes(32'h160), 8'h00);
        send(lanes(32'h170), 8'h00);
        @(negedge clk);
        chk("s3_eop", {255'd0, eop_out}, 256'd1);
        @(posedge clk); #1;

        // Scenario 4: reset mid-instruction
        send(lanes(32'h200), 8'h44);
        send(lanes(32'h210), 8'h00);
        send(lanes(32'h220), 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("s4_valid", {255'd0, valid_out}, 256'd0);
        chk("s4_data", data_out, 256'd0);
        chk("s4_thread", {254'd0, thread_out}, 256'd0);
        chk("s4_tag", {248'd0, tag_out}, 256'd0);
        chk("s4_eop", {255'd0, eop_out}, 256'd0);
        chk("s4_busy", {255'd0, busy}, 256'd0);
        chk("s4_ready_in", {255'd0, ready_in}, 256'd1);
        @(posedge clk); #1;
        send(lanes(32'h300), 8'h33);
        send(lanes(32'h310), 8'h99);
        @(negedge clk);
        chk("s4_new_valid", {255'd0, valid_out}, 256'd1);
        chk("s4_new_thread", {254'd0, thread_out}, 256'd0);
        chk("s4_new_tag", {248'd0, tag_out}, 256'h33);
        chk("s4_new_data", data_out, {lanes(32'h310), lanes(32'h300)});
        @(posedge clk); #1;
        send(lanes(32'h320), 8'h00); send(lanes(32'h330), 8'h00);
        send(lanes(32'h340), 8'h00); send(lanes(32'h350), 8'h00);
        send(lanes(32'h360), 8'h00); send(lanes(32'h370), 8'h00);
        repeat (2) @(posedge clk); #1;

        // Scenario 5: random valid gaps and backpressure, scenario 1 data
        cap_q.delete();
        cap_en = 1'b1;
        rnd_rdy = 1'b1;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(lanes((r / 2) * 32 + (r % 2) * 16), (r == 0) ? 8'h5A : 8'hC3);
        end
        for (int n = 0; n < 2 * BEATS * NT; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send({$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
        end
        @(posedge clk); #1;
        rnd_rdy = 1'b0;
        #1 ready_out = 1'b1;
        for (int i = 0; i < 20 && (valid_out || busy); i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        cap_en = 1'b0;
        chk("s5_drained", {255'd0, busy}, 256'd0);
        chk("s5_out_count", 256'(cap_q.size()), 256'd12);
        for (int t = 0; t < 4; t++) begin
            if (cap_q.size() > t)
                chk("s5_vector", cap_q[t], {lanes(t * 32 + 16), lanes(t * 32)});
        end
        @(posedge clk); #1;

        // Scenario 6: one beat per thread
        b_ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_valid_in = 1'b1;
            b_data_in  = lanes(32'h400 + i * 16);
            b_tag_in   = (i == 0) ? 8'h66 : 8'h11;
            @(negedge clk);
            chk("s6_ready_in", {255'd0, b_ready_in}, 256'd1);
            @(posedge clk); #1;
            chk("s6_valid", {255'd0, b_valid_out}, 256'd1);
            chk("s6_thread", {254'd0, b_thread_out}, 256'(i % 4));
            chk("s6_data", {128'd0, b_data_out}, {128'd0, lanes(32'h400 + i * 16)});
            chk("s6_eop", {255'd0, b_eop_out}, 256'((i % 4) == 3));
            chk("s6_tag", {248'd0, b_tag_out}, (i < 4) ? 256'h66 : 256'h11);
        end
        b_valid_in = 1'b0;
        @(posedge clk); #1;
        chk("s6_valid_idle", {255'd0, b_valid_out}, 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
